// File: rtl/ct_f_spsram_init.sv
// rtl/ct_f_spsram_init.sv - parametrised single-port FPGA SRAM with post-reset fill sweep
// One fpga_ram per write lane; the sweep owns the array port until INIT_DONE.

module fpga_ram #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_en,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [WIDTH-1:0]      i_din,
   output logic [WIDTH-1:0]      o_dout
);
   logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
   logic [WIDTH-1:0] r_dout;

   // Write-first: a written lane returns the new data on the same access.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_din;
            r_dout        <= i_din;
         end else begin
            r_dout <= r_mem[i_addr];
         end
      end
   end

   assign o_dout = r_dout;
endmodule

module ct_f_spsram_init #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    LANE_WIDTH = 8,
   parameter int                    OUT_REG    = 0,
   parameter int                    INIT_EN    = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [DATA_WIDTH-1:0] WEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_BUSY,
   output logic                  INIT_DONE,
   output logic                  ACC_DROP
);
   localparam int LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

   typedef enum logic [1:0] {ST_RESET, ST_SWEEP, ST_READY} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH:0]   r_cnt;
   logic [ADDR_WIDTH-1:0] r_hold;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_drop;

   logic                  w_en;
   logic [LANES-1:0]      w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_din;
   logic [DATA_WIDTH-1:0] w_ram_q;
   logic                  w_unused_wen;

   // Only the MSB of each lane is a real enable; the rest are don't-care.
   assign w_unused_wen = ^WEN;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_RESET;
         r_cnt   <= '0;
         r_hold  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         case (r_state)
            ST_RESET: begin
               if (INIT_EN != 0) begin
                  r_state <= ST_SWEEP;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_READY;
                  r_done  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               r_cnt <= r_cnt + 1'b1;
               if (!CEN) r_drop <= 1'b1;
               if (r_cnt == C_LAST) begin
                  r_state <= ST_READY;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_READY: begin
               if (!CEN) r_hold <= A;
            end
            default: r_state <= ST_RESET;
         endcase
      end
   end

   always_comb begin
      w_en   = 1'b0;
      w_we   = '0;
      w_addr = r_hold;
      w_din  = D;
      case (r_state)
         ST_SWEEP: begin
            w_en   = 1'b1;
            w_we   = '1;
            w_addr = r_cnt[ADDR_WIDTH-1:0];
            w_din  = INIT_VALUE;
         end
         ST_READY: begin
            w_en   = 1'b1;
            w_addr = CEN ? r_hold : A;
            for (int i = 0; i < LANES; i++) begin
               w_we[i] = !CEN && !GWEN && !WEN[(i+1)*LANE_WIDTH-1];
            end
         end
         default: ;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fpga_ram #(
         .WIDTH      (LANE_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
         .i_clk  (CLK),
         .i_en   (w_en),
         .i_we   (w_we[g]),
         .i_addr (w_addr),
         .i_din  (w_din[g*LANE_WIDTH +: LANE_WIDTH]),
         .o_dout (w_ram_q[g*LANE_WIDTH +: LANE_WIDTH])
      );
   end

   // Q is held at zero until READY so partial sweep data never leaks out.
   if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_q;
      always_ff @(posedge CLK) begin
         if (RST)                     r_q <= '0;
         else if (r_state == ST_READY) r_q <= w_ram_q;
         else                         r_q <= '0;
      end
      assign Q = r_q;
   end else begin : g_odir
      assign Q = (r_state == ST_READY) ? w_ram_q : '0;
   end

   assign INIT_BUSY = r_busy;
   assign INIT_DONE = r_done;
   assign ACC_DROP  = r_drop;
endmodule

// File: tb/tb_ct_f_spsram_init.sv
// tb/tb_ct_f_spsram_init.sv - scoreboard bench for ct_f_spsram_init (two configurations)

module tb_ct_f_spsram_init;
   localparam int          D0    = 1024;
   localparam int          D1    = 16;
   localparam logic [31:0] INIT0 = 32'h5A5A5A5A;
   localparam logic [63:0] INIT1 = 64'h0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst0, cen0, gwen0, busy0, done0, drop0;
   logic [31:0] wen0, d0, q0;
   logic [9:0]  a0;
   logic        rst1, cen1, gwen1, busy1, done1, drop1;
   logic [63:0] wen1, d1, q1;
   logic [3:0]  a1;

   ct_f_spsram_init #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10), .LANE_WIDTH(8), .OUT_REG(0), .INIT_EN(1), .INIT_VALUE(INIT0)
   ) u_dut0 (
      .CLK(clk), .RST(rst0), .CEN(cen0), .GWEN(gwen0), .WEN(wen0), .A(a0), .D(d0),
      .Q(q0), .INIT_BUSY(busy0), .INIT_DONE(done0), .ACC_DROP(drop0)
   );

   ct_f_spsram_init #(
      .DATA_WIDTH(64), .ADDR_WIDTH(4), .LANE_WIDTH(16), .OUT_REG(1), .INIT_EN(1), .INIT_VALUE(INIT1)
   ) u_dut1 (
      .CLK(clk), .RST(rst1), .CEN(cen1), .GWEN(gwen1), .WEN(wen1), .A(a1), .D(d1),
      .Q(q1), .INIT_BUSY(busy1), .INIT_DONE(done1), .ACC_DROP(drop1)
   );

   typedef struct {
      int          due;
      int          kind;   // 0 Q, 1 INIT_BUSY, 2 INIT_DONE, 3 ACC_DROP
      logic [63:0] exp;
      string       nm;
   } chk_t;

   chk_t sq0[$];
   chk_t sq1[$];
   int   total = 0;
   int   bad   = 0;

   logic [31:0] m0 [0:D0-1];
   logic [9:0]  h0;
   logic [63:0] m1 [0:D1-1];
   logic [3:0]  h1;

   function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wen, logic [63:0] d,
                                         int lw, int lanes);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < lw*lanes; b++)
         if (!wen[(b/lw + 1)*lw - 1]) r[b] = d[b];
      return r;
   endfunction

   task automatic push(int dut, int lat, int kind, logic [63:0] e, string nm);
      chk_t c;
      c.due = cyc + lat; c.kind = kind; c.exp = e; c.nm = nm;
      if (dut == 0) sq0.push_back(c); else sq1.push_back(c);
   endtask

   function automatic logic [63:0] actual(int dut, int kind);
      if (dut == 0)
         case (kind) 0: return {32'b0, q0}; 1: return {63'b0, busy0};
                     2: return {63'b0, done0}; default: return {63'b0, drop0}; endcase
      else
         case (kind) 0: return q1; 1: return {63'b0, busy1};
                     2: return {63'b0, done1}; default: return {63'b0, drop1}; endcase
   endfunction

   task automatic judge(int dut, chk_t c);
      logic [63:0] a;
      a = actual(dut, c.kind);
      total++;
      if (a !== c.exp) begin
         bad++;
         $display("FAIL dut%0d %s @cyc %0d: got 0x%0h want 0x%0h", dut, c.nm, cyc, a, c.exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < sq0.size(); ) begin
         if (sq0[i].due <= cyc) begin judge(0, sq0[i]); sq0.delete(i); end
         else i++;
      end
      for (int i = 0; i < sq1.size(); ) begin
         if (sq1[i].due <= cyc) begin judge(1, sq1[i]); sq1.delete(i); end
         else i++;
      end
   end

   task automatic reset0(bit full);
      @(posedge clk); #1;
      rst0 = 1'b1; cen0 = 1'b1;
      push(0, 1, 0, 0, "rst_q"); push(0, 1, 1, 0, "rst_busy");
      push(0, 1, 2, 0, "rst_done"); push(0, 1, 3, 0, "rst_drop");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst0 = 1'b0;
      push(0, 0, 1, 0, "busy_before_rise");
      push(0, 1, 1, 1, "busy_rise"); push(0, 1, 2, 0, "done_during_sweep");
      if (full) begin
         push(0, D0, 1, 1, "busy_last"); push(0, D0, 2, 0, "done_before_end");
         push(0, D0+1, 1, 0, "busy_fall"); push(0, D0+1, 2, 1, "done_rise");
         for (int i = 0; i < D0; i++) m0[i] = INIT0;
         h0 = '0;
      end
   endtask

   task automatic sweep0(int n, bit drop_test);
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         cen0 = 1'b1; gwen0 = 1'b1; a0 = 10'($urandom); d0 = $urandom;
         if (drop_test && i == 40) begin
            push(0, 0, 3, 0, "drop_clear_in_sweep"); push(0, 0, 0, 0, "q_zero_in_sweep");
         end
         if (drop_test && i == 100) begin
            cen0 = 1'b0; gwen0 = 1'b0; wen0 = '0; a0 = 10'd3; d0 = 32'hFFFFFFFF;
            push(0, 1, 3, 1, "drop_set");
         end
      end
   endtask

   task automatic acc0(logic cen, logic gwen, logic [31:0] wen, logic [9:0] a, logic [31:0] d, string nm);
      @(posedge clk); #1;
      cen0 = cen; gwen0 = gwen; wen0 = wen; a0 = a; d0 = d;
      if (!cen) begin
         if (!gwen) m0[a] = 32'(merge({32'b0, m0[a]}, {32'b0, wen}, {32'b0, d}, 8, 4));
         h0 = a;
      end
      push(0, 1, 0, {32'b0, m0[h0]}, nm);
   endtask

   task automatic reset1();
      @(posedge clk); #1;
      rst1 = 1'b1; cen1 = 1'b1;
      push(1, 1, 0, 0, "rst_q"); push(1, 1, 1, 0, "rst_busy"); push(1, 1, 2, 0, "rst_done");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst1 = 1'b0;
      push(1, 1, 1, 1, "busy_rise"); push(1, D1, 1, 1, "busy_last");
      push(1, D1+1, 1, 0, "busy_fall"); push(1, D1+1, 2, 1, "done_rise");
      push(1, 5, 0, 0, "q_zero_in_sweep");
      for (int i = 0; i < D1; i++) m1[i] = INIT1;
      h1 = '0;
      for (int i = 1; i <= D1; i++) begin
         @(posedge clk); #1;
         cen1 = 1'b1; a1 = 4'($urandom); d1 = {$urandom, $urandom};
      end
   endtask

   task automatic acc1(logic cen, logic gwen, logic [63:0] wen, logic [3:0] a, logic [63:0] d, string nm);
      @(posedge clk); #1;
      cen1 = cen; gwen1 = gwen; wen1 = wen; a1 = a; d1 = d;
      if (!cen) begin
         if (!gwen) m1[a] = merge(m1[a], wen, d, 16, 4);
         h1 = a;
      end
      push(1, 2, 0, m1[h1], nm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst0 = 1'b1; cen0 = 1'b1; gwen0 = 1'b1; wen0 = '1; a0 = '0; d0 = '0;
      rst1 = 1'b1; cen1 = 1'b1; gwen1 = 1'b1; wen1 = '1; a1 = '0; d1 = '0;
      h0 = '0; h1 = '0;

      // Power-up sweep with a dropped write to address 3 in the middle.
      reset0(1'b1);
      sweep0(D0, 1'b1);
      acc0(0, 1, '1, 10'd3,    $urandom, "rd_addr3_after_drop");
      acc0(0, 1, '1, 10'd0,    $urandom, "rd_addr0");
      acc0(0, 1, '1, 10'd511,  $urandom, "rd_addr511");
      acc0(0, 1, '1, 10'd1023, $urandom, "rd_addr1023");
      push(0, 0, 3, 1, "drop_sticky");

      // Lane write.
      acc0(0, 0, 32'h0,        10'd5, 32'hAABBCCDD, "wr5_full");
      acc0(0, 0, 32'hFFFF00FF, 10'd5, 32'h11223344, "wr5_lane1");
      push(0, 1, 0, 64'hAABB33DD, "wr5_lane1_const");
      acc0(0, 1, '1,           10'd5, 32'h0,        "rd5");
      push(0, 1, 0, 64'hAABB33DD, "rd5_const");

      // Address holding.
      acc0(0, 0, 32'h0, 10'd7, 32'h12345678, "wr7");
      acc0(0, 1, '1,    10'd7, 32'h0,        "rd7");
      for (int i = 0; i < 10; i++) begin
         acc0(1, 0, 32'h0, 10'($urandom), $urandom, "hold");
         push(0, 1, 0, 64'h12345678, "hold_const");
      end
      for (int i = 0; i < 4; i++) acc0(0, 1, '1, 10'(i + 8), 0, "rd_after_hold");

      // Random mixed traffic on a narrow address window to force collisions.
      for (int i = 0; i < 300; i++) begin
         acc0(($urandom_range(0, 4) == 0), 1'($urandom), $urandom,
              (i % 3 == 0) ? 10'($urandom) : 10'($urandom_range(0, 31)), $urandom, "rand0");
      end

      // Reset mid-sweep, then a full sweep must restore address 1023.
      acc0(0, 0, 32'h0, 10'd1023, 32'hDEADBEEF, "wr1023");
      reset0(1'b0);
      sweep0(299, 1'b0);
      push(0, 0, 1, 1, "busy_at_abort");
      reset0(1'b1);
      sweep0(D0, 1'b0);
      acc0(0, 1, '1, 10'd1023, 0, "rd1023_after_abort");
      acc0(0, 1, '1, 10'd3,    0, "rd3_after_abort");

      // Wide, registered-output configuration.
      reset1();
      for (int i = 0; i < D1; i++)
         acc1(0, 0, (i % 4 == 0) ? 64'h0000FFFF0000FFFF : 64'h0, 4'(i), {$urandom, $urandom}, "wr1");
      for (int i = 0; i < D1; i++) acc1(0, 1, '1, 4'(i), 0, "stream_rd1");
      for (int i = 0; i < 100; i++)
         acc1(($urandom_range(0, 4) == 0), 1'($urandom), {$urandom, $urandom}, 4'($urandom),
              {$urandom, $urandom}, "rand1");
      acc1(1, 1, '1, 0, 0, "idle1");

      for (int i = 0; i < 20 && (sq0.size() + sq1.size()) > 0; i++) @(posedge clk);
      foreach (sq0[i]) begin total++; bad++; $display("FAIL dut0 %s: never checked", sq0[i].nm); end
      foreach (sq1[i]) begin total++; bad++; $display("FAIL dut1 %s: never checked", sq1[i].nm); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ct_f_spsram_init.md
# ct_f_spsram_init

Parametrised single-port FPGA SRAM wrapper for the C910-class FPGA memory library. It generalises the fixed 1024x32 byte-lane wrappers in four ways: configurable data width, depth and write-lane granularity, plus an optional output pipeline register. After every reset it runs a hardware initialisation sweep that fills the array with a known value, so cache tag and valid arrays come up clean on FPGA without a software flush. It is built from `fpga_ram` lane instances and is a drop-in replacement wherever a `ct_f_spsram_*` macro is instantiated.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH
- ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH
- LANE_WIDTH, 8, write-mask granularity; one `fpga_ram` instance per lane
- OUT_REG, 0, 0: Q direct from array; 1: extra output register stage
- INIT_EN, 1, 1: run fill sweep after reset; 0: ready one cycle after reset release
- INIT_VALUE, 0, DATA_WIDTH-bit fill word written by the sweep

- CLK  input  1  clock; all logic is on the rising edge
- RST  input  1  synchronous, active-high reset
- CEN  input  1  chip enable, active low
- GWEN  input  1  global write enable, active low
- WEN  input  DATA_WIDTH  bit write mask, active low; only the MSB of each lane is used
- A  input  ADDR_WIDTH  address
- D  input  DATA_WIDTH  write data
- Q  output  DATA_WIDTH  read data
- INIT_BUSY  output  1  fill sweep in progress
- INIT_DONE  output  1  array ready for accesses
- ACC_DROP  output  1  sticky flag: an access was attempted while INIT_BUSY was high

## Operation
- The FSM has three states: RESET, SWEEP and READY.
- RST=1 forces RESET, clears the sweep counter, and clears ACC_DROP, Q (including the OUT_REG stage), INIT_BUSY and INIT_DONE.
- When RST is released, the FSM moves to SWEEP if INIT_EN=1, otherwise to READY.
- SWEEP:
  - Each cycle, the block writes INIT_VALUE to address `cnt` with all lanes enabled, then increments `cnt`.
  - After the cycle that writes DEPTH-1, the FSM goes to READY. `cnt` is ADDR_WIDTH+1 bits wide so it never wraps.
- READY: the FSM stays here until RST.
- Lane write enable: lane i is written when CEN=0, GWEN=0 and WEN[(i+1)*LANE_WIDTH-1]=0. The other WEN bits are ignored.
- Address holding: when CEN=0 the array uses A and the holding register captures A. When CEN=1 the array is driven from the holding register, so Q keeps showing the last accessed word.
- Write-first: in a write cycle, the Q produced by that access shows the word after the write (written lanes new, unwritten lanes old).
- While INIT_BUSY=1:
  - External CEN, GWEN, WEN, A and D are ignored. The sweep owns the array port.
  - The holding register is not updated.
  - If CEN=0, ACC_DROP is set to 1 and stays 1 until RST.
- Q is forced to 0 while in RESET or SWEEP, so no X values or partial sweep data appear.
- RST asserted mid-sweep aborts the sweep. The sweep restarts from address 0 after release.
- The array contents are not otherwise altered by RST.

## Timing
- Reset values: Q=0, INIT_BUSY=0, INIT_DONE=0, ACC_DROP=0.
- INIT_BUSY rises on the first edge after RST falls and stays high for exactly DEPTH cycles. INIT_DONE rises on the same edge INIT_BUSY falls.
- With INIT_EN=0: INIT_DONE=1 one cycle after RST falls, and INIT_BUSY stays 0.
- The first external access is accepted in the cycle INIT_DONE=1 is first visible.
- Read latency, with A/CEN sampled at edge N:
  - OUT_REG=0: Q is valid after edge N.
  - OUT_REG=1: Q is valid after edge N+1.
- Back-to-back accesses are supported every cycle, and any mix of reads and writes is allowed.
- No backpressure. Software or the integrating logic must wait for INIT_DONE.

## Test plan
- Default parameters: pulse RST for 2 cycles -> INIT_BUSY high for exactly 1024 cycles, then INIT_DONE=1. Reads of addresses 0, 511 and 1023 return 0x00000000.
- Lane write: write 0xAABBCCDD to address 5 with WEN all 0. Then write D=0x11223344 with only WEN[15:8]=0 -> Q on that access and on the next read of address 5 is 0xAABB33DD.
- Address holding: read address 7 (value 0x12345678), then hold CEN=1 for 10 cycles while toggling A and D -> Q stays 0x12345678 and no write occurs.
- Reset mid-sweep: assert RST at sweep cycle 300 -> Q=0, INIT_BUSY and INIT_DONE go to 0. After release, a full 1024-cycle sweep runs and address 1023 reads INIT_VALUE.
- Access during busy: with INIT_VALUE=0x5A5A5A5A, drive a CEN=0 write of 0xFFFFFFFF to address 3 during the sweep -> ACC_DROP=1 and stays set. After INIT_DONE, address 3 reads 0x5A5A5A5A. RST clears ACC_DROP.
- OUT_REG=1, DATA_WIDTH=64, LANE_WIDTH=16, ADDR_WIDTH=4: the sweep lasts 16 cycles. A read issued at edge N returns data after edge N+1. Back-to-back reads of addresses 0..15 stream one word per cycle.
